// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: transmitter bit states plus the types and
// constants used by the transmit FIFO issue controller.
package uart_tx_fifo_pkg;

   typedef logic [7:0] byte_t;

   // Serializer bit-level states of the UART transmitter.
   typedef enum logic [1:0] {
      TXB_IDLE  = 2'd0,
      TXB_START = 2'd1,
      TXB_DATA  = 2'd2,
      TXB_STOP  = 2'd3
   } tx_bit_state_e;

   // Issue controller states between the FIFO and the transmitter.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ACK  = 2'd2,
      S_DONE = 2'd3
   } issue_state_e;

   localparam int unsigned FIFO_DEPTH_DEFAULT = 16;

   // Cycles without tx_busy in S_ACK before the request is repeated.
   localparam int unsigned                ACK_TIMER_WIDTH = 3;
   localparam logic [ACK_TIMER_WIDTH-1:0] ACK_TIMEOUT     = 3'd4;

   // Saturating increment for the acknowledge timer.
   function automatic logic [ACK_TIMER_WIDTH-1:0] ack_timer_inc(
      input logic [ACK_TIMER_WIDTH-1:0] t
   );
      return (t == '1) ? t : t + 1'b1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Writer handshake and transmitter request bundle around the TX FIFO.
// The slave side is the FIFO; the master side is the writer together
// with the transmitter that answers with tx_busy.
interface uart_tx_fifo_if;
   import uart_tx_fifo_pkg::*;

   logic  wr_valid;
   byte_t wr_data;
   logic  wr_ready;
   logic  tx_valid;
   byte_t tx_data;
   logic  tx_busy;

   modport master (
      output wr_valid,
      output wr_data,
      output tx_busy,
      input  wr_ready,
      input  tx_valid,
      input  tx_data
   );

   modport slave (
      input  wr_valid,
      input  wr_data,
      input  tx_busy,
      output wr_ready,
      output tx_valid,
      output tx_data
   );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo_ctrl.sv
// Circular FIFO bookkeeping: write/read pointers, occupancy count and
// full/empty flags. Callers only assert push/pop when legal; flush wins
// over both and returns the FIFO to its empty state.
module sync_fifo_ctrl
   import uart_tx_fifo_pkg::*;
#(
   parameter  int unsigned DEPTH      = FIFO_DEPTH_DEFAULT,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   output logic [ADDR_WIDTH-1:0] wr_ptr,
   output logic [ADDR_WIDTH-1:0] rd_ptr,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full
);

   localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q,  count_d;

   // Next pointer/count values; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_ptr = wr_ptr_q;
   assign rd_ptr = rd_ptr_q;
   assign count  = count_q;
   assign empty  = (count_q == '0);
   assign full   = (count_q == COUNT_FULL);

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and issue controller in front of the UART transmitter.
// Bytes enter through a valid/ready handshake, are stored in a circular
// array and are handed to the transmitter one at a time.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter  int unsigned DEPTH      = FIFO_DEPTH_DEFAULT,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   uart_tx_fifo_if.slave       bus,
   output logic [ADDR_WIDTH:0] count,
   output logic                empty,
   output logic                full,
   output logic                drained
);

   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;

   byte_t mem_q [DEPTH];
   byte_t mem_d [DEPTH];

   issue_state_e                state_q,     state_d;
   byte_t                       tx_data_q,   tx_data_d;
   logic [ACK_TIMER_WIDTH-1:0]  ack_timer_q, ack_timer_d;

   // A write is taken whenever the writer offers and there is room;
   // flush discards anything offered in the same cycle.
   assign push = bus.wr_valid && !full && !flush;

   sync_fifo_ctrl #(
      .DEPTH (DEPTH)
   ) u_ctrl (
      .clock  (clock),
      .reset  (reset),
      .flush  (flush),
      .push   (push),
      .pop    (pop),
      .wr_ptr (wr_ptr),
      .rd_ptr (rd_ptr),
      .count  (count),
      .empty  (empty),
      .full   (full)
   );

   // Storage array write port.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr] = bus.wr_data;
      end
   end

   // Issue FSM: pop into the holding register, pulse the request, then
   // follow tx_busy; an unanswered request is repeated after ACK_TIMEOUT.
   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      ack_timer_d = ack_timer_q;
      pop         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty && !flush) begin
               pop       = 1'b1;
               tx_data_d = mem_q[rd_ptr];
               state_d   = S_REQ;
            end
         end
         S_REQ: begin
            ack_timer_d = '0;
            state_d     = S_ACK;
         end
         S_ACK: begin
            if (bus.tx_busy) begin
               state_d = S_DONE;
            end else begin
               ack_timer_d = ack_timer_inc(ack_timer_q);
               if (ack_timer_d == ACK_TIMEOUT) begin
                  state_d = S_REQ;
               end
            end
         end
         S_DONE: begin
            if (!bus.tx_busy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM, holding register, ack timer and storage registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         tx_data_q   <= '0;
         ack_timer_q <= '0;
         mem_q       <= '{default: '0};
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         ack_timer_q <= ack_timer_d;
         mem_q       <= mem_d;
      end
   end

   assign bus.wr_ready = !full;
   assign bus.tx_valid = (state_q == S_REQ);
   assign bus.tx_data  = tx_data_q;
   assign drained      = empty && (state_q == S_IDLE) && !bus.tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized bench for uart_tx_fifo with a queue-based
// reference model and a behavioural transmitter.
module tb_uart_tx_fifo;
   import uart_tx_fifo_pkg::*;

   localparam int unsigned DEPTH = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic       flush;
   logic [4:0] count;
   logic       empty;
   logic       full;
   logic       drained;

   uart_tx_fifo_if bus();

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clock   (clock),
      .reset   (reset),
      .flush   (flush),
      .bus     (bus),
      .count   (count),
      .empty   (empty),
      .full    (full),
      .drained (drained)
   );

   always #5 clock = ~clock;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   bit    mon_en = 0;
   byte_t ref_q[$];
   byte_t delivered[$];
   bit    inflight = 0;
   byte_t inflight_byte = '0;
   bit    retry_pend = 0;
   int    ign_cyc = 0;
   bit    ignore_one = 0;
   bit    xmt_hold = 0;
   int    busy_len = 20;
   int    left = 0;
   logic  busy_next;
   logic  prev_valid = 1'b0;
   int    fresh_cnt = 0;
   int    retry_cnt = 0;
   int    last_req_cyc = 0;
   int    wr_cyc = 0;
   bit    wr_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe at the falling edge, update models, then apply
   // the transmitter's busy flag just after the rising edge.
   task automatic step();
      bit is_retry;
      is_retry = 0;
      @(negedge clock);
      cyc++;
      wr_acc    = 0;
      busy_next = bus.tx_busy;
      if (mon_en) begin
         if (retry_pend && (bus.tx_valid || cyc == ign_cyc + 5)) begin
            chk("retry_gap", cyc - ign_cyc, 5);
            chk("retry_valid", bus.tx_valid, 1);
            if (bus.tx_valid) chk("retry_data", bus.tx_data, inflight_byte);
            is_retry   = bus.tx_valid;
            retry_pend = 0;
            if (is_retry) retry_cnt++;
         end
         if (bus.tx_valid) begin
            chk("valid_one_cycle", prev_valid, 0);
            if (!is_retry) begin
               chk("pop_from_nonempty", ref_q.size() != 0, 1);
               if (ref_q.size() != 0) inflight_byte = ref_q.pop_front();
               chk("pop_data", bus.tx_data, inflight_byte);
               inflight     = 1;
               fresh_cnt++;
               last_req_cyc = cyc;
            end
         end
         chk("count", count, ref_q.size());
         chk("empty", empty, ref_q.size() == 0);
         chk("full", full, ref_q.size() == DEPTH);
         chk("wr_ready", bus.wr_ready, ref_q.size() != DEPTH);
         if (inflight) chk("tx_data_stable", bus.tx_data, inflight_byte);
         if (ref_q.size() != 0 || bus.tx_busy) chk("drained_low", drained, 0);
      end
      prev_valid = bus.tx_valid;
      // transmitter: accepts only while idle, busy for busy_len cycles
      if (!bus.tx_busy) begin
         if (bus.tx_valid) begin
            if (ignore_one) begin
               ignore_one = 0;
               retry_pend = 1;
               ign_cyc    = cyc;
            end else begin
               busy_next = 1'b1;
               left      = busy_len;
               delivered.push_back(bus.tx_data);
            end
         end
      end else if (!xmt_hold) begin
         left--;
         if (left <= 0) begin
            busy_next = 1'b0;
            inflight  = 0;
         end
      end
      // writer side of the reference queue
      if (flush) begin
         ref_q.delete();
      end else if (bus.wr_valid && ref_q.size() < DEPTH) begin
         ref_q.push_back(bus.wr_data);
         wr_acc = 1;
         wr_cyc = cyc;
      end
      if (reset) begin
         ref_q.delete();
         inflight   = 0;
         retry_pend = 0;
         ignore_one = 0;
         busy_next  = 1'b0;
         left       = 0;
         prev_valid = 1'b0;
      end
      @(posedge clock);
      #1;
      bus.tx_busy = busy_next;
      #1;
   endtask

   task automatic put(input byte_t b, input int budget);
      bus.wr_valid = 1'b1;
      bus.wr_data  = b;
      for (int i = 0; i < budget; i++) begin
         step();
         if (wr_acc) break;
      end
      chk("write_accepted", wr_acc, 1);
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_drained(input int budget);
      for (int i = 0; i < budget && !drained; i++) step();
      chk("drained_reached", drained, 1);
   endtask

   task automatic wait_busy(input int budget);
      for (int i = 0; i < budget && !bus.tx_busy; i++) step();
      chk("tx_busy_reached", bus.tx_busy, 1);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_wr_ready"}, bus.wr_ready, 1);
      chk({tag, "_tx_valid"}, bus.tx_valid, 0);
      chk({tag, "_tx_data"}, bus.tx_data, 8'h00);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_empty"}, empty, 1);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_drained"}, drained, 1);
   endtask

   initial begin
      int    base_d;
      int    base_f;
      int    base_r;
      int    n;
      byte_t sent[$];

      reset        = 1'b1;
      flush        = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.tx_busy  = 1'b0;
      repeat (3) step();
      check_reset_values("rst");
      reset  = 1'b0;
      mon_en = 1;

      // single byte into an idle FIFO
      busy_len = 20;
      base_f   = fresh_cnt;
      put(8'h41, 4);
      for (int i = 0; i < 10 && fresh_cnt == base_f; i++) step();
      chk("t1_req_seen", fresh_cnt - base_f, 1);
      chk("t1_latency", last_req_cyc - wr_cyc, 2);
      wait_drained(60);
      chk("t1_delivered", delivered[$], 8'h41);
      chk("t1_busy_low", bus.tx_busy, 0);

      // fill to DEPTH behind a stalled transmitter
      busy_len = 4;
      xmt_hold = 1;
      base_d   = delivered.size();
      put(8'hAA, 4);
      wait_busy(10);
      for (int b = 0; b < 16; b++) put(byte_t'(b), 2);
      chk("t2_count16", count, 16);
      chk("t2_full", full, 1);
      chk("t2_wr_ready", bus.wr_ready, 0);
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h10;
      repeat (4) begin
         step();
         chk("t2_held_off", bus.wr_ready, 0);
      end
      chk("t2_still_full", count, 16);
      xmt_hold = 0;
      put(8'h10, 100);
      for (int i = 0; i < 600 && delivered.size() < base_d + 18; i++) step();
      chk("t2_n", delivered.size() - base_d, 18);
      for (int b = 0; b < 16; b++) chk("t2_order", delivered[base_d + 1 + b], b);
      chk("t2_last", delivered[base_d + 17], 8'h10);
      wait_drained(40);

      // random writes wrapping the pointers
      base_d = delivered.size();
      n      = 0;
      bus.wr_valid = 1'b0;
      for (int i = 0; i < 3000 && n < 40; i++) begin
         busy_len = $urandom_range(1, 5);
         if (!bus.wr_valid || wr_acc) begin
            bus.wr_valid = ($urandom_range(0, 3) != 0);
            bus.wr_data  = byte_t'($urandom);
         end
         step();
         if (wr_acc) begin
            sent.push_back(bus.wr_data);
            n++;
         end
      end
      bus.wr_valid = 1'b0;
      chk("t3_written", n, 40);
      for (int i = 0; i < 1000 && delivered.size() < base_d + 40; i++) step();
      chk("t3_n", delivered.size() - base_d, 40);
      for (int i = 0; i < 40 && i < sent.size(); i++)
         chk("t3_order", delivered[base_d + i], sent[i]);
      wait_drained(40);

      // first request ignored by the transmitter
      busy_len   = 6;
      ignore_one = 1;
      base_r     = retry_cnt;
      base_f     = fresh_cnt;
      base_d     = delivered.size();
      put(8'h5A, 4);
      for (int i = 0; i < 30 && retry_cnt == base_r; i++) step();
      chk("t4_retry_seen", retry_cnt - base_r, 1);
      chk("t4_one_pop", fresh_cnt - base_f, 1);
      wait_drained(50);
      chk("t4_once", delivered.size() - base_d, 1);
      chk("t4_data", delivered[$], 8'h5A);

      // flush with one byte in flight and five queued
      busy_len = 30;
      base_f   = fresh_cnt;
      base_d   = delivered.size();
      put(8'h55, 4);
      for (int b = 0; b < 5; b++) put(byte_t'(8'h60 + b), 2);
      wait_busy(10);
      chk("t5_count5", count, 5);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t5_count0", count, 0);
      chk("t5_empty", empty, 1);
      wait_drained(60);
      repeat (10) step();
      chk("t5_no_more", fresh_cnt - base_f, 1);
      chk("t5_n", delivered.size() - base_d, 1);
      chk("t5_data", delivered[$], 8'h55);

      // reset while waiting in S_DONE with three queued
      busy_len = 20;
      put(8'hA1, 4);
      put(8'hB1, 2);
      put(8'hB2, 2);
      put(8'hB3, 2);
      wait_busy(10);
      chk("t6_count3", count, 3);
      base_f = fresh_cnt;
      reset  = 1'b1;
      step();
      check_reset_values("t6");
      reset = 1'b0;
      repeat (30) step();
      chk("t6_no_valid", fresh_cnt - base_f, 0);
      chk("t6_count", count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and issue controller that sits directly upstream of the UART transmitter. It accepts bytes from a bus-side writer through a valid/ready handshake and stores them in a DEPTH-entry circular FIFO. It then hands them one at a time to the transmitter's `tx_valid`/`tx_data_in`/`tx_busy` interface. This lets software post bursts of characters without polling per byte.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `ADDR_WIDTH`, $clog2(DEPTH): pointer width (derived localparam, not overridden).
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous clear of FIFO contents; an in-flight byte still completes.
- `wr_valid` in 1: writer presents a byte.
- `wr_data` in 8: byte to enqueue.
- `wr_ready` out 1: FIFO can accept; equals `!full`.
- `tx_valid` out 1: one-cycle request to the transmitter.
- `tx_data` out 8: byte to the transmitter; held stable from the request until the byte is done.
- `tx_busy` in 1: transmitter busy flag.
- `count` out ADDR_WIDTH+1: bytes stored, 0..DEPTH.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == DEPTH`.
- `drained` out 1: empty, FSM in S_IDLE, and `tx_busy` low; the line is quiet.

## Operation
- Storage: DEPTH×8 register array.
  - `wr_ptr`/`rd_ptr` are ADDR_WIDTH bits and wrap modulo DEPTH.
  - `count` is a separate up/down counter.
- Write: `wr_valid && wr_ready` at an edge stores `wr_data` at `wr_ptr`, increments `wr_ptr`, and increments `count`.
  - `wr_valid` with `!wr_ready` is dropped. The writer must hold the byte.
- Pop: occurs only in S_IDLE when `!empty` and `!flush`.
  - Loads `tx_data <= mem[rd_ptr]`, increments `rd_ptr`, decrements `count`, and asserts `tx_valid` for the next cycle.
- Simultaneous write and pop: `count` is unchanged and both pointers advance.
  - When full, `wr_ready` is low, so there is no write even if a pop occurs that cycle.
- Transmitter contract:
  - The transmitter samples `tx_valid` only when it is idle.
  - It raises `tx_busy` the cycle after accepting.
  - It lowers `tx_busy` on the first idle cycle with `tx_valid` low.
- Issue FSM:
  - S_IDLE: on `!empty && !flush`, pop and go to S_REQ.
  - S_REQ: `tx_valid=1` for exactly this cycle; go to S_ACK.
  - S_ACK: `tx_valid=0`; on `tx_busy=1` go to S_DONE. If `tx_busy` stays 0 for 4 cycles, go to S_REQ and re-request the same `tx_data` (no re-pop).
  - S_DONE: on `tx_busy=0` go to S_IDLE.
- `flush`:
  - Clears `wr_ptr`, `rd_ptr`, and `count` to 0.
  - Blocks the write and the pop in that cycle.
  - Leaves the FSM and `tx_data` untouched, so the current byte finishes normally.
- Reset mid-transfer:
  - All state returns to reset values and the queued bytes are lost.
  - The transmitter is reset by the same `reset` net.

## Timing
- Reset values: `wr_ready=1`, `tx_valid=0`, `tx_data=8'h00`, `count=0`, `empty=1`, `full=0`, `drained=1` (given `tx_busy=0`). FSM = S_IDLE, pointers = 0, ack timer = 0.
- `count`, `empty`, `full`, and `wr_ready` are registered or derived from registers. They update the cycle after the write/pop edge.
- Latency into an empty FIFO with an idle FSM:
  - Write accepted at edge N.
  - Pop at edge N+1.
  - `tx_valid` high during cycle N+1..N+2.
- Back-to-back bytes: the next pop happens on the first S_IDLE cycle after `tx_busy` falls. Inter-byte gap = transmitter's idle cycles + 1 clock.
- `tx_valid` is never high for two consecutive cycles.
- `tx_data` never changes while FSM ≠ S_IDLE.
- Ack timer: 3-bit, cleared on entering S_ACK, saturates. The timeout fires when the timer reaches 4 with `tx_busy` still 0.

## Structure
- State encodings (S_IDLE, S_REQ, S_ACK, S_DONE) and ACK_TIMEOUT=4 go in the shared UART package, next to the transmitter's bit-state constants.
- One natural sub-module: `sync_fifo_ctrl`, covering pointers, count, full/empty, and flush. The array and issue FSM stay in `uart_tx_fifo`.
- Top-level pairing with the transmitter is done in the UART wrapper, not here.

## Test plan
- Reset, then write 8'h41 (transmitter model: busy 1 cycle after valid, 20 cycles long) -> `tx_valid` pulses 1 cycle after `count` becomes 1; `tx_data=8'h41`; `drained` returns to 1 after `tx_busy` falls.
- Write 16 bytes 8'h00..8'h0F back-to-back with the transmitter stalled busy -> `full=1` after the 16th write (count=16), `wr_ready=0`, a 17th write is held off; bytes emerge in order 00..0F.
- Sustained writes while the FIFO cycles wrap-around (40 bytes, DEPTH=16) -> all 40 bytes are delivered in order, with no duplicates or drops.
- Transmitter model ignores the first request -> `tx_valid` is re-asserted exactly 5 cycles later with the same byte; `count` is not decremented twice.
- `flush` while byte 8'h55 is in flight with 5 queued -> 8'h55 completes, `count=0`, no further `tx_valid`.
- Assert `reset` during S_DONE with 3 queued -> next cycle all outputs are at reset values and no `tx_valid` follows.
